// File: rtl/csa_seq_ctrl_pkg.sv
// Shared definitions for the sequential carry-select adder controller.
// Used by csa_seq_ctrl and csa_slice; the CSA_OVF_EN feature is handled in those files.
package csa_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SEG   = 8;

    // Segment counter width; never below one bit.
    function automatic int cnt_width(input int nseg);
        return (nseg <= 2) ? 1 : $clog2(nseg);
    endfunction

endpackage

// File: rtl/csa_slice.sv
// Combinational SEG-bit carry-select slice: two ripple adders (carry-in 0 and 1) and a mux bank.
// With CSA_OVF_EN defined it also exports the carry into the MSB of the selected hypothesis.
module csa_slice
    import csa_seq_ctrl_pkg::*;
#(
    parameter int SEG = DEFAULT_SEG
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           sel,
    output logic [SEG-1:0] sum,
    output logic           cout
`ifdef CSA_OVF_EN
    , output logic         msb_cin
`endif
);

    logic [SEG:0]   c0;
    logic [SEG:0]   c1;
    logic [SEG-1:0] s0;
    logic [SEG-1:0] s1;

    assign c0[0] = 1'b0;
    assign c1[0] = 1'b1;

    for (genvar gi = 0; gi < SEG; gi++) begin : g_bit
        assign s0[gi]    = a[gi] ^ b[gi] ^ c0[gi];
        assign c0[gi+1]  = (a[gi] & b[gi]) | (c0[gi] & (a[gi] ^ b[gi]));
        assign s1[gi]    = a[gi] ^ b[gi] ^ c1[gi];
        assign c1[gi+1]  = (a[gi] & b[gi]) | (c1[gi] & (a[gi] ^ b[gi]));
        assign sum[gi]   = sel ? s1[gi] : s0[gi];
    end

    assign cout = sel ? c1[SEG] : c0[SEG];

`ifdef CSA_OVF_EN
    assign msb_cin = sel ? c1[SEG-1] : c0[SEG-1];
`endif

endmodule

// File: rtl/csa_seq_ctrl.sv
// Sequential carry-select adder: WIDTH-bit add over WIDTH/SEG cycles through one shared slice.
// Define CSA_OVF_EN to add the registered signed-overflow output ovf.
module csa_seq_ctrl
    import csa_seq_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG   = DEFAULT_SEG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef CSA_OVF_EN
    , output logic           ovf
`endif
);

    localparam int NSEG = WIDTH / SEG;
    localparam int CW   = cnt_width(NSEG);
    localparam logic [CW-1:0] LAST = CW'(NSEG - 1);

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
    logic             carry_reg;
    logic [CW-1:0]    cnt_reg;
    logic [SEG-1:0]   slice_sum;
    logic             slice_cout;
`ifdef CSA_OVF_EN
    logic             slice_msb_cin;
    logic             ovf_reg;
`endif

    csa_slice #(.SEG(SEG)) u_slice (
        .a    (a_reg[SEG-1:0]),
        .b    (b_reg[SEG-1:0]),
        .sel  (carry_reg),
        .sum  (slice_sum),
        .cout (slice_cout)
`ifdef CSA_OVF_EN
        , .msb_cin (slice_msb_cin)
`endif
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        case (state_reg)
            IDLE: begin
                ready = 1'b1;
                if (start) state_next = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (cnt_reg == LAST) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cnt_reg   <= '0;
`ifdef CSA_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else if (state_reg == IDLE && start) begin
            a_reg     <= a;
            b_reg     <= b;
            sum_reg   <= '0;
            carry_reg <= cin;
            cnt_reg   <= '0;
`ifdef CSA_OVF_EN
            ovf_reg   <= 1'b0;
`endif
        end else if (state_reg == RUN) begin
            // Result segments enter at the top so the LSB segment ends at bit 0.
            sum_reg   <= {slice_sum, sum_reg[WIDTH-1:SEG]};
            a_reg     <= a_reg >> SEG;
            b_reg     <= b_reg >> SEG;
            carry_reg <= slice_cout;
            if (cnt_reg != LAST) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
`ifdef CSA_OVF_EN
            if (cnt_reg == LAST) begin
                ovf_reg <= slice_msb_cin ^ slice_cout;
            end
`endif
        end
    end

    assign sum  = sum_reg;
    assign cout = carry_reg;
`ifdef CSA_OVF_EN
    assign ovf  = ovf_reg;
`endif

endmodule

// File: tb/tb_csa_seq_ctrl.sv
// Bench for csa_seq_ctrl: three instances (SEG 4/8/16) checked every cycle against a timeline model.
// Honors CSA_OVF_EN when defined.
module tb_csa_seq_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    bit fin [3];

    task automatic check(input string name, input int seg, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s seg=%0d: got 0x%0h expected 0x%0h", name, seg, act, exp);
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g_inst
        localparam int SEG  = (gi == 0) ? 4 : (gi == 1) ? 8 : 16;
        localparam int NSEG = 32 / SEG;

        logic        rst = 1'b1, start = 1'b0, cin = 1'b0;
        logic [31:0] a = '0, b = '0;
        logic        ready, busy, done, cout;
        logic [31:0] sum;
`ifdef CSA_OVF_EN
        logic        ovf;
        logic        exp_ovf = 1'b0;
`endif
        // k = cycles since the accepting edge (1..NSEG run, NSEG+1 done), -1 when idle
        int          k = -1;
        logic [31:0] exp_sum = '0;
        logic        exp_cout = 1'b0;

        csa_seq_ctrl #(.WIDTH(32), .SEG(SEG)) dut (
            .clk   (clk),
            .rst   (rst),
            .start (start),
            .a     (a),
            .b     (b),
            .cin   (cin),
            .ready (ready),
            .busy  (busy),
            .done  (done),
            .sum   (sum),
            .cout  (cout)
`ifdef CSA_OVF_EN
            , .ovf (ovf)
`endif
        );

        initial forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                k        = -1;
                exp_sum  = '0;
                exp_cout = 1'b0;
`ifdef CSA_OVF_EN
                exp_ovf  = 1'b0;
`endif
            end else if (k < 0) begin
                if (start) begin
                    k = 1;
                    {exp_cout, exp_sum} = 33'(a) + 33'(b) + 33'(cin);
`ifdef CSA_OVF_EN
                    exp_ovf = (a[31] == b[31]) && (exp_sum[31] != a[31]);
`endif
                end
            end else if (k == NSEG + 1) begin
                k = -1;
            end else begin
                k++;
            end
        end

        initial forever begin
            @(negedge clk);
            check("ready", SEG, 64'(ready), 64'(k < 0));
            check("busy",  SEG, 64'(busy),  64'(k >= 1 && k <= NSEG));
            check("done",  SEG, 64'(done),  64'(k == NSEG + 1));
            if (k < 0 || k == NSEG + 1) begin
                check("sum",  SEG, 64'(sum),  64'(exp_sum));
                check("cout", SEG, 64'(cout), 64'(exp_cout));
`ifdef CSA_OVF_EN
                check("ovf",  SEG, 64'(ovf),  64'(exp_ovf));
`endif
            end
        end

        task automatic op(input logic [31:0] ta, input logic [31:0] tb, input logic tc,
                          input bit lit, input logic [31:0] lsum, input logic lcout);
            int w = 0;
            while (!ready && w < 50) begin
                @(posedge clk); #1; w++;
            end
            check("ready_wait", SEG, 64'(ready), 64'd1);
            start = 1'b1; a = ta; b = tb; cin = tc;
            @(posedge clk); #1;
            start = 1'b0; a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
            w = 0;
            while (!done && w < NSEG + 5) begin
                @(posedge clk); #1; w++;
            end
            check("latency", SEG, 64'(w + 1), 64'(NSEG + 1));
            if (lit) begin
                check("sum_lit",  SEG, 64'(sum),  64'(lsum));
                check("cout_lit", SEG, 64'(cout), 64'(lcout));
            end
        endtask

        initial begin
            int w;
            repeat (2) @(posedge clk);
            #1 rst = 1'b0;
            check("rst_sum", SEG, 64'(sum), 64'd0);

            op(32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
            op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b1, 32'h2345_678A, 1'b0);
            op(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b1, 32'h0000_0000, 1'b1);
`ifdef CSA_OVF_EN
            op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h8000_0000, 1'b0);
            check("ovf_lit", SEG, 64'(ovf), 64'd1);
            op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 32'h0000_0000, 1'b1);
            check("ovf_lit", SEG, 64'(ovf), 64'd0);
`endif

            // start held with changing operands: only accepted samples matter
            start = 1'b1;
            repeat (12) begin
                a = $urandom; b = $urandom; cin = 1'($urandom_range(0, 1));
                @(posedge clk); #1;
            end
            start = 1'b0;
            w = 0;
            while (!ready && w < 50) begin
                @(posedge clk); #1; w++;
            end
            check("held_ready", SEG, 64'(ready), 64'd1);

            // reset in RUN cycle 2
            start = 1'b1; a = 32'hDEAD_BEEF; b = 32'h0F0F_0F0F; cin = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            @(posedge clk); #1;
            rst = 1'b1;
            #1;
            check("abort_sum",   SEG, 64'(sum),   64'd0);
            check("abort_cout",  SEG, 64'(cout),  64'd0);
            check("abort_ready", SEG, 64'(ready), 64'd1);
            @(posedge clk); #1;
            rst = 1'b0;
            repeat (NSEG + 2) begin
                @(posedge clk); #1;
            end
            op(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1, 32'h0000_0001, 1'b1);

            for (int i = 0; i < 1000; i++) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, 32'h0, 1'b0);
            end
            repeat (3) @(posedge clk);
            fin[gi] = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 90000; c++) begin
            @(posedge clk);
            if (fin[0] && fin[1] && fin[2]) break;
        end
        check("timeout", 0, 64'(fin[0] && fin[1] && fin[2]), 64'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
